// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and source encodings for the common data bus arbiter.
package cdb_pkg;
  localparam int DATA_W = 32;
  localparam int ROB_POS_W = 4;
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side result ports and the registered CDB broadcast, bundled for the arbiter.
interface cdb_arbiter_if #(
  parameter int PW = cdb_pkg::ROB_POS_W,
  parameter int DW = cdb_pkg::DATA_W
);
  import cdb_pkg::*;

  // Handshake: a result moves on a source when rdy && valid && ready on the same
  // rising edge; ready depends only on registered FIFO occupancy, and producers
  // keep valid low while ready is low.
  logic          alu_valid;
  logic [PW-1:0] alu_rob_pos;
  logic [DW-1:0] alu_val;
  logic          alu_ready;
  logic          lsb_valid;
  logic [PW-1:0] lsb_rob_pos;
  logic [DW-1:0] lsb_val;
  logic          lsb_ready;
  logic          cdb_valid;
  logic [PW-1:0] cdb_rob_pos;
  logic [DW-1:0] cdb_val;
  logic          cdb_src;

  modport master (
    output alu_valid, alu_rob_pos, alu_val, input alu_ready,
    output lsb_valid, lsb_rob_pos, lsb_val, input lsb_ready,
    input  cdb_valid, cdb_rob_pos, cdb_val, cdb_src
  );

  modport slave (
    input  alu_valid, alu_rob_pos, alu_val, output alu_ready,
    input  lsb_valid, lsb_rob_pos, lsb_val, output lsb_ready,
    output cdb_valid, cdb_rob_pos, cdb_val, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-source result FIFO: circular buffer with occupancy count, run-gated, flushable.
module result_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 36
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_rdy,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_rdy) begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (i_rdy && !i_flush && i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB between the ALU and LSB result FIFOs.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ROB_POS_W = cdb_pkg::ROB_POS_W,
  parameter int DATA_W = cdb_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rdy,
  input  logic                   rollback,
  cdb_arbiter_if.slave           bus,
  output logic [$clog2(DEPTH):0] o_alu_count,
  output logic [$clog2(DEPTH):0] o_lsb_count,
  output logic                   o_last_grant
);
  localparam int EW = ROB_POS_W + DATA_W;

  logic          w_alu_full, w_alu_empty, w_lsb_full, w_lsb_empty;
  logic [EW-1:0] w_alu_head, w_lsb_head;
  logic          w_alu_xfer, w_lsb_xfer;
  logic          w_alu_cand, w_lsb_cand;
  logic [EW-1:0] w_alu_data, w_lsb_data, w_grant_data;
  logic          w_grant_valid, w_grant_src;
  logic          w_alu_push, w_alu_pop, w_lsb_push, w_lsb_pop;

  logic                 r_cdb_valid;
  logic [ROB_POS_W-1:0] r_cdb_rob_pos;
  logic [DATA_W-1:0]    r_cdb_val;
  logic                 r_cdb_src;
  logic                 r_last_grant;

  assign bus.alu_ready = !w_alu_full;
  assign bus.lsb_ready = !w_lsb_full;

  // Inputs presented during a rollback are dropped, never queued or bypassed.
  assign w_alu_xfer = rdy && !rollback && bus.alu_valid && !w_alu_full;
  assign w_lsb_xfer = rdy && !rollback && bus.lsb_valid && !w_lsb_full;

  assign w_alu_cand = !w_alu_empty || w_alu_xfer;
  assign w_lsb_cand = !w_lsb_empty || w_lsb_xfer;
  assign w_alu_data = w_alu_empty ? {bus.alu_rob_pos, bus.alu_val} : w_alu_head;
  assign w_lsb_data = w_lsb_empty ? {bus.lsb_rob_pos, bus.lsb_val} : w_lsb_head;

  always_comb begin
    w_grant_valid = rdy && !rollback && (w_alu_cand || w_lsb_cand);
    w_grant_src   = SRC_ALU;
    if (w_alu_cand && w_lsb_cand) w_grant_src = ~r_last_grant;
    else if (w_lsb_cand)          w_grant_src = SRC_LSB;
    w_grant_data  = (w_grant_src == SRC_LSB) ? w_lsb_data : w_alu_data;
  end

  // A granted empty-FIFO source is served by bypass, so its input is not written.
  assign w_alu_pop  = w_grant_valid && (w_grant_src == SRC_ALU) && !w_alu_empty;
  assign w_lsb_pop  = w_grant_valid && (w_grant_src == SRC_LSB) && !w_lsb_empty;
  assign w_alu_push = w_alu_xfer && !(w_grant_valid && (w_grant_src == SRC_ALU) && w_alu_empty);
  assign w_lsb_push = w_lsb_xfer && !(w_grant_valid && (w_grant_src == SRC_LSB) && w_lsb_empty);

  result_fifo #(.DEPTH(DEPTH), .W(EW)) u_alu_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_rdy   (rdy),
    .i_flush (rollback),
    .i_push  (w_alu_push),
    .i_pop   (w_alu_pop),
    .i_data  ({bus.alu_rob_pos, bus.alu_val}),
    .o_head  (w_alu_head),
    .o_count (o_alu_count),
    .o_full  (w_alu_full),
    .o_empty (w_alu_empty)
  );

  result_fifo #(.DEPTH(DEPTH), .W(EW)) u_lsb_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_rdy   (rdy),
    .i_flush (rollback),
    .i_push  (w_lsb_push),
    .i_pop   (w_lsb_pop),
    .i_data  ({bus.lsb_rob_pos, bus.lsb_val}),
    .o_head  (w_lsb_head),
    .o_count (o_lsb_count),
    .o_full  (w_lsb_full),
    .o_empty (w_lsb_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cdb_valid   <= 1'b0;
      r_cdb_rob_pos <= '0;
      r_cdb_val     <= '0;
      r_cdb_src     <= SRC_ALU;
      r_last_grant  <= SRC_LSB;
    end else if (rollback) begin
      r_cdb_valid  <= 1'b0;
      r_last_grant <= SRC_LSB;
    end else if (rdy) begin
      r_cdb_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_cdb_rob_pos <= w_grant_data[EW-1:DATA_W];
        r_cdb_val     <= w_grant_data[DATA_W-1:0];
        r_cdb_src     <= w_grant_src;
        r_last_grant  <= w_grant_src;
      end
    end
  end

  assign bus.cdb_valid   = r_cdb_valid;
  assign bus.cdb_rob_pos = r_cdb_rob_pos;
  assign bus.cdb_val     = r_cdb_val;
  assign bus.cdb_src     = r_cdb_src;
  assign o_last_grant    = r_last_grant;
endmodule
